// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, imem address driver and IF/ID register with stall, redirect and HALT
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          IMEM_BYTES  = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  localparam logic [31:0] MASK = 32'(IMEM_BYTES - 1);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nxt;
  logic [31:0] pc, pc_seq;
  logic is_halt;
  assign pc_seq = (pc + 32'd4) & MASK;
  assign is_halt = instr_in[31:26] == HALT_OPCODE;
  assign instr_addr = pc;
  always_ff @(posedge clk)
    state <= !rst_n ? RUN : state_nxt;
  always_comb
    state_nxt = redirect ? RUN : stall ? state : (state == RUN && is_halt) ? HALTED : state;
  always_comb
    halted = state == HALTED;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc          <= {redirect_pc[31:2], 2'b00} & MASK;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (state == RUN) begin
        if_id_instr <= instr_in;
        if_id_pc    <= pc;
        if_id_pc4   <= pc_seq;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
        pc          <= is_halt ? pc : pc_seq;
      end else begin
        if_id_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed literal checks plus randomized run against a behavioural fetch model
module tb_fetch_stage;
  localparam int IMEM = 32;
  logic clk = 0, rst_n = 0, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0, instr_addr, instr_in;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_count;
  logic if_id_valid, halted;
  logic [31:0] mem [8];
  int total = 0, bad = 0;
  bit chk_on = 0;
  logic [31:0] m_pc, m_ins, m_ipc, m_ipc4, m_cnt, w;
  logic m_val, m_halt;
  logic [31:0] sv_pc, sv_cnt;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr_in(instr_in),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign instr_in = mem[instr_addr[4:2]];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0; m_ins = 0; m_ipc = 0; m_ipc4 = 0; m_val = 0; m_halt = 0; m_cnt = 0;
    end else if (redirect) begin
      m_pc = ((redirect_pc / 4) * 4) % IMEM;
      m_val = 0;
      m_halt = 0;
    end else if (!stall) begin
      if (m_halt) m_val = 0;
      else begin
        w = mem[m_pc / 4];
        m_ins = w; m_ipc = m_pc; m_ipc4 = (m_pc + 4) % IMEM; m_val = 1; m_cnt = m_cnt + 1;
        if (w[31:26] == 6'h3F) m_halt = 1;
        else m_pc = (m_pc + 4) % IMEM;
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("m_addr", instr_addr, m_pc);
    chk("m_valid", 32'(if_id_valid), 32'(m_val));
    chk("m_halted", 32'(halted), 32'(m_halt));
    chk("m_count", fetch_count, m_cnt);
    if (m_val) begin
      chk("m_instr", if_id_instr, m_ins);
      chk("m_pc", if_id_pc, m_ipc);
      chk("m_pc4", if_id_pc4, m_ipc4);
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = {1'b0, 31'($urandom)};
    mem[0] = 32'h00221890;
    tick; tick;
    chk_on = 1;
    chk("rst_addr", instr_addr, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    rst_n = 1;
    tick;
    chk("first_instr", if_id_instr, 32'h00221890);
    chk("first_pc", if_id_pc, 32'h0);
    chk("first_pc4", if_id_pc4, 32'h4);
    chk("first_valid", 32'(if_id_valid), 32'h1);
    chk("first_count", fetch_count, 32'h1);
    chk("addr4", instr_addr, 32'h4);
    redirect = 1; redirect_pc = 32'h0C;
    tick;
    redirect = 0;
    chk("redir_addr", instr_addr, 32'h0C);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    tick;
    chk("redir_ifpc", if_id_pc, 32'h0C);
    chk("redir_valid2", 32'(if_id_valid), 32'h1);
    redirect = 1; redirect_pc = 32'h8;
    tick;
    redirect = 0;
    sv_pc = if_id_pc; sv_cnt = fetch_count;
    stall = 1;
    tick; tick; tick;
    chk("stall_addr", instr_addr, 32'h8);
    chk("stall_ifpc", if_id_pc, sv_pc);
    chk("stall_count", fetch_count, sv_cnt);
    stall = 0;
    tick;
    chk("unstall_ifpc", if_id_pc, 32'h8);
    mem[7] = 32'hFC00001C;
    redirect = 1; redirect_pc = 32'd28;
    tick;
    redirect = 0;
    chk("halt_pre_addr", instr_addr, 32'd28);
    tick;
    chk("halt_instr", if_id_instr, 32'hFC00001C);
    chk("halt_valid", 32'(if_id_valid), 32'h1);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_addr", instr_addr, 32'd28);
    tick;
    chk("halt_bubble", 32'(if_id_valid), 32'h0);
    chk("halt_addr2", instr_addr, 32'd28);
    redirect = 1; redirect_pc = 32'h0;
    tick;
    redirect = 0;
    chk("resume_halted", 32'(halted), 32'h0);
    chk("resume_addr", instr_addr, 32'h0);
    tick;
    chk("resume_valid", 32'(if_id_valid), 32'h1);
    redirect = 1; redirect_pc = 32'd28;
    tick;
    redirect_pc = 32'h10;
    tick;
    redirect = 0;
    chk("halt_redir_halted", 32'(halted), 32'h0);
    chk("halt_redir_addr", instr_addr, 32'h10);
    mem[7] = 32'h12345678;
    redirect = 1; redirect_pc = 32'd28;
    tick;
    redirect = 0;
    tick;
    chk("wrap_addr", instr_addr, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_ifpc", if_id_pc, 32'd28);
    for (int i = 0; i < 400; i++) begin
      stall = $urandom_range(0, 3) == 0;
      redirect = $urandom_range(0, 7) == 0;
      redirect_pc = $urandom;
      if ($urandom_range(0, 4) == 0)
        mem[$urandom_range(0, 7)] = ($urandom_range(0, 3) == 0) ? {6'h3F, 26'($urandom)} : {1'b0, 31'($urandom)};
      rst_n = $urandom_range(0, 49) != 0;
      tick;
      if (!rst_n) begin
        chk("midrst_addr", instr_addr, 32'h0);
        chk("midrst_valid", 32'(if_id_valid), 32'h0);
        chk("midrst_count", fetch_count, 32'h0);
        chk("midrst_instr", if_id_instr, 32'h0);
      end
    end
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
